// File: rtl/tracesys_capture_mem.sv
// tracesys_capture_mem
//   Single-port trace RAM shared between an Avalon-MM host slave and an
//   Avalon-ST capture sink. The capture side fills the RAM as a linear
//   (STOP_ON_FULL=1) or circular (STOP_ON_FULL=0) trace buffer.
//
//   Optional build macro: TRACE_TIMESTAMP_EN
//     When defined, each captured word carries a free-running TS_WIDTH-bit
//     timestamp in its upper bits in place of the top st_data bits.
//
//   Handshake rules:
//     - Capture beat is transferred on a cycle where st_valid & st_ready.
//       st_ready never depends on st_valid, only on FSM state, freeze,
//       host request and the arbitration toggle.
//     - Host command is accepted on a cycle where chipselect & (read|write)
//       & ~waitrequest. A read accepted in cycle N returns readdata with a
//       one-cycle readdatavalid pulse in cycle N+2.
//     - When host and capture both request, the one RAM port alternates
//       between them with a 1-bit toggle that starts in favour of capture.
//
//   Capture state is visible through capturing/done (IDLE = neither).

module tracesys_capture_mem #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 13,
    parameter int STOP_ON_FULL = 1,
    parameter int TS_WIDTH     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    input  logic [DATA_WIDTH-1:0]   st_data,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic                    arm,
    input  logic                    stop,
    output logic                    capturing,
    output logic                    done,
    output logic                    wrapped,
    output logic [ADDR_WIDTH-1:0]   wr_ptr
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Elaboration-time sanity check of the configuration.
    if ((DATA_WIDTH % 8) != 0 || TS_WIDTH >= DATA_WIDTH || TS_WIDTH < 1) begin : g_bad_params
        $error("tracesys_capture_mem: illegal DATA_WIDTH/TS_WIDTH combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q;
    logic                    wrapped_q;
    logic                    toggle_q;
    logic                    toggle_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_rd_q;
    logic                    rd_pend_q;
    logic                    rd_pend_d;
    logic [DATA_WIDTH-1:0]   readdata_q;
    logic [DATA_WIDTH-1:0]   readdata_d;
    logic                    readdatavalid_q;
    logic                    readdatavalid_d;

    logic                    freeze;
    logic                    blocked;
    logic                    in_capture;
    logic                    host_req;
    logic                    cap_req;
    logic                    contended;
    logic                    host_gnt;
    logic                    cap_gnt;
    logic                    host_wr;
    logic                    host_rd;
    logic [DATA_WIDTH-1:0]   cap_word;

    // ------------------------------------------------------------------
    // Freeze and request decode
    // ------------------------------------------------------------------
    assign freeze     = ~clken | reset_req;
    assign blocked    = reset | freeze;
    assign in_capture = (state_q == ST_CAPTURE);
    assign host_req   = chipselect & (read | write);
    assign cap_req    = st_valid & in_capture;
    assign contended  = host_req & cap_req;

    // Toggle low: capture wins a contended cycle; toggle high: host wins.
    assign cap_gnt  = ~blocked & cap_req  & ~(host_req & toggle_q);
    assign host_gnt = ~blocked & host_req & ~(cap_req & ~toggle_q);

    // A command with both read and write set is treated as a write.
    assign host_wr  = host_gnt & write;
    assign host_rd  = host_gnt & read & ~write;

    assign st_ready    = ~blocked & in_capture & ~(host_req & toggle_q);
    assign waitrequest = blocked | (host_req & cap_req & ~toggle_q);

    // ------------------------------------------------------------------
    // Captured word formation
    // ------------------------------------------------------------------
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;

    // Free-running timestamp, advancing on every unfrozen cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else if (!freeze) begin
            ts_q <= ts_q + {{(TS_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign cap_word = {ts_q, st_data[DATA_WIDTH-TS_WIDTH-1:0]};
`else
    assign cap_word = st_data;
`endif

    // ------------------------------------------------------------------
    // Arbitration toggle
    // ------------------------------------------------------------------
    // Flip only when a contended cycle actually grants someone.
    always_comb begin
        toggle_d = toggle_q;
        if (contended && !blocked) begin
            toggle_d = ~toggle_q;
        end
    end

    // Toggle register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    // ------------------------------------------------------------------
    // RAM: one port, write from capture or host, read from host
    // ------------------------------------------------------------------
    // RAM array write and registered read stage (no reset, RAM-style).
    always_ff @(posedge clk) begin
        if (cap_gnt) begin
            mem[wr_ptr_q] <= cap_word;
        end else if (host_wr) begin
            for (int b = 0; b < BE_W; b++) begin
                if (byteenable[b]) begin
                    mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
        if (host_rd) begin
            ram_rd_q <= mem[address];
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: RAM stage then output register, held while frozen
    // ------------------------------------------------------------------
    // Next-state for the read pipeline; everything holds while frozen.
    always_comb begin
        rd_pend_d       = rd_pend_q;
        readdatavalid_d = readdatavalid_q;
        readdata_d      = readdata_q;
        if (!freeze) begin
            rd_pend_d       = host_rd;
            readdatavalid_d = rd_pend_q;
            if (rd_pend_q) begin
                readdata_d = ram_rd_q;
            end
        end
    end

    // Read pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q       <= 1'b0;
            readdatavalid_q <= 1'b0;
            readdata_q      <= '0;
        end else begin
            rd_pend_q       <= rd_pend_d;
            readdatavalid_q <= readdatavalid_d;
            readdata_q      <= readdata_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

    // ------------------------------------------------------------------
    // Capture FSM with write pointer and wrap flag
    // ------------------------------------------------------------------
    // arm (re)starts from any state and outranks stop; a beat accepted
    // alongside stop is still counted because the write uses cap_gnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            wrapped_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_q   <= ST_CAPTURE;
                        wr_ptr_q  <= '0;
                        wrapped_q <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (arm) begin
                        wr_ptr_q  <= '0;
                        wrapped_q <= 1'b0;
                    end else begin
                        if (cap_gnt) begin
                            if (wr_ptr_q == PTR_MAX) begin
                                wr_ptr_q  <= '0;
                                wrapped_q <= 1'b1;
                                if (STOP_ON_FULL != 0) begin
                                    state_q <= ST_DONE;
                                end
                            end else begin
                                wr_ptr_q <= wr_ptr_q + PTR_ONE;
                            end
                        end
                        if (stop) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (arm) begin
                        state_q   <= ST_CAPTURE;
                        wr_ptr_q  <= '0;
                        wrapped_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign capturing = (state_q == ST_CAPTURE);
    assign done      = (state_q == ST_DONE);
    assign wrapped   = wrapped_q;
    assign wr_ptr    = wr_ptr_q;

endmodule

// File: tb/tb_tracesys_capture_mem.sv
// Bench for tracesys_capture_mem: two small instances (ADDR_WIDTH=4) share
// all inputs; dut_a is circular (STOP_ON_FULL=0), dut_b is linear (=1).
module tb_tracesys_capture_mem;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          reset_req;
    logic          clken;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic [DW-1:0] st_data;
    logic          st_valid;
    logic          arm;
    logic          stop;

    logic [DW-1:0] a_readdata, b_readdata;
    logic          a_rdv, b_rdv;
    logic          a_wait, b_wait;
    logic          a_st_ready, b_st_ready;
    logic          a_capturing, b_capturing;
    logic          a_done, b_done;
    logic          a_wrapped, b_wrapped;
    logic [AW-1:0] a_wr_ptr, b_wr_ptr;

    int errors = 0;
    int checks = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    tracesys_capture_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STOP_ON_FULL(0), .TS_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata),
        .readdata(a_readdata), .readdatavalid(a_rdv), .waitrequest(a_wait),
        .st_data(st_data), .st_valid(st_valid), .st_ready(a_st_ready),
        .arm(arm), .stop(stop), .capturing(a_capturing), .done(a_done),
        .wrapped(a_wrapped), .wr_ptr(a_wr_ptr)
    );

    tracesys_capture_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STOP_ON_FULL(1), .TS_WIDTH(8)) dut_b (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata),
        .readdata(b_readdata), .readdatavalid(b_rdv), .waitrequest(b_wait),
        .st_data(st_data), .st_valid(st_valid), .st_ready(b_st_ready),
        .arm(arm), .stop(stop), .capturing(b_capturing), .done(b_done),
        .wrapped(b_wrapped), .wr_ptr(b_wr_ptr)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic        arm;
        logic        stop;
        logic        sv;
        logic [31:0] sd;
        logic        cs;
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        e_ready;
        logic        e_wait;
        logic        e_rdv;
        logic        chk_rd;
        logic [31:0] e_rdata;
        logic [3:0]  e_ptr;
        logic        e_cap;
        logic        e_done;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset_req  = 1'b0;
        clken      = 1'b1;
        address    = '0;
        byteenable = '0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        st_data    = '0;
        st_valid   = 1'b0;
        arm        = 1'b0;
        stop       = 1'b0;
    endtask

    // Single non-pipelined host read with no stream traffic.
    task automatic host_read(input logic [3:0] addr, input logic [31:0] exp_a,
                             input logic [31:0] exp_b, input string name);
        tick();
        chipselect = 1'b1; read = 1'b1; address = addr;
        @(negedge clk);
        chk({name, "_wait"}, 32'(a_wait), 32'd0);
        tick();
        chipselect = 1'b0; read = 1'b0;
        @(negedge clk);
        chk({name, "_rdv_early"}, 32'(a_rdv), 32'd0);
        tick();
        @(negedge clk);
        chk({name, "_rdv"}, 32'(a_rdv), 32'd1);
        chk({name, "_a_data"}, a_readdata, exp_a);
        chk({name, "_b_data"}, b_readdata, exp_b);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout, expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int  idx;
        bit  pending;

        // Field order: arm stop sv sd cs rd wr addr be wd | e_ready e_wait e_rdv chk_rd e_rdata e_ptr e_cap e_done
        vecs[0]  = '{0,0,0,32'h0 ,0,0,0,4'd0,4'h0,32'h0,        0,0,0,0,32'h0,       4'd0,0,0};
        vecs[1]  = '{1,0,0,32'h0 ,0,0,0,4'd0,4'h0,32'h0,        0,0,0,0,32'h0,       4'd0,0,0};
        vecs[2]  = '{0,0,1,32'h11,0,0,0,4'd0,4'h0,32'h0,        1,0,0,0,32'h0,       4'd0,1,0};
        vecs[3]  = '{0,0,1,32'h22,0,0,0,4'd0,4'h0,32'h0,        1,0,0,0,32'h0,       4'd1,1,0};
        vecs[4]  = '{0,0,1,32'h33,0,0,0,4'd0,4'h0,32'h0,        1,0,0,0,32'h0,       4'd2,1,0};
        vecs[5]  = '{0,0,1,32'h44,0,0,0,4'd0,4'h0,32'h0,        1,0,0,0,32'h0,       4'd3,1,0};
        vecs[6]  = '{0,0,0,32'h0 ,1,1,0,4'd0,4'h0,32'h0,        1,0,0,0,32'h0,       4'd4,1,0};
        vecs[7]  = '{0,0,0,32'h0 ,1,1,0,4'd1,4'h0,32'h0,        1,0,0,0,32'h0,       4'd4,1,0};
        vecs[8]  = '{0,0,0,32'h0 ,1,1,0,4'd2,4'h0,32'h0,        1,0,1,1,32'h11,      4'd4,1,0};
        vecs[9]  = '{0,0,0,32'h0 ,1,1,0,4'd3,4'h0,32'h0,        1,0,1,1,32'h22,      4'd4,1,0};
        vecs[10] = '{0,0,0,32'h0 ,0,0,0,4'd0,4'h0,32'h0,        1,0,1,1,32'h33,      4'd4,1,0};
        vecs[11] = '{0,0,0,32'h0 ,1,0,1,4'd5,4'hF,32'h0,        1,0,1,1,32'h44,      4'd4,1,0};
        vecs[12] = '{0,0,0,32'h0 ,1,0,1,4'd5,4'h5,32'hAABBCCDD, 1,0,0,0,32'h0,       4'd4,1,0};
        vecs[13] = '{0,0,0,32'h0 ,1,1,0,4'd5,4'h0,32'h0,        1,0,0,0,32'h0,       4'd4,1,0};
        vecs[14] = '{0,0,0,32'h0 ,0,0,0,4'd0,4'h0,32'h0,        1,0,0,0,32'h0,       4'd4,1,0};
        vecs[15] = '{0,0,0,32'h0 ,0,0,0,4'd0,4'h0,32'h0,        1,0,1,1,32'h00BB00DD,4'd4,1,0};
        vecs[16] = '{0,0,0,32'h0 ,0,0,0,4'd0,4'h0,32'h0,        1,0,0,0,32'h0,       4'd4,1,0};

        // ---- reset ----
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wait",      32'(a_wait),      32'd1);
        chk("rst_st_ready",  32'(a_st_ready),  32'd0);
        chk("rst_rdv",       32'(a_rdv),       32'd0);
        chk("rst_rdata",     a_readdata,       32'd0);
        chk("rst_wr_ptr",    32'(a_wr_ptr),    32'd0);
        chk("rst_wrapped",   32'(a_wrapped),   32'd0);
        chk("rst_capturing", 32'(a_capturing), 32'd0);
        chk("rst_done",      32'(a_done),      32'd0);
        reset = 1'b0;

        // ---- table: capture 4 beats, pipelined reads, byte-enable write ----
        for (int i = 0; i < NVEC; i++) begin
            tick();
            arm = vecs[i].arm;   stop = vecs[i].stop;
            st_valid = vecs[i].sv; st_data = vecs[i].sd;
            chipselect = vecs[i].cs; read = vecs[i].rd; write = vecs[i].wr;
            address = vecs[i].addr; byteenable = vecs[i].be; writedata = vecs[i].wd;
            @(negedge clk);
            chk($sformatf("v%0d_a_ready", i), 32'(a_st_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d_b_ready", i), 32'(b_st_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d_wait", i),    32'(a_wait),     32'(vecs[i].e_wait));
            chk($sformatf("v%0d_rdv", i),     32'(a_rdv),      32'(vecs[i].e_rdv));
            if (vecs[i].chk_rd) begin
                chk($sformatf("v%0d_a_rdata", i), a_readdata, vecs[i].e_rdata);
                chk($sformatf("v%0d_b_rdata", i), b_readdata, vecs[i].e_rdata);
            end
            chk($sformatf("v%0d_a_ptr", i),  32'(a_wr_ptr),    32'(vecs[i].e_ptr));
            chk($sformatf("v%0d_b_ptr", i),  32'(b_wr_ptr),    32'(vecs[i].e_ptr));
            chk($sformatf("v%0d_cap", i),    32'(a_capturing), 32'(vecs[i].e_cap));
            chk($sformatf("v%0d_done", i),   32'(a_done),      32'(vecs[i].e_done));
        end

        // ---- wrap: 20 beats of value k after a restart arm ----
        tick();
        idle_inputs();
        arm = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            tick();
            arm = 1'b0;
            st_valid = 1'b1;
            st_data = 32'(k);
            @(negedge clk);
            chk($sformatf("wrap%0d_a_ready", k), 32'(a_st_ready), 32'd1);
            chk($sformatf("wrap%0d_a_ptr", k),   32'(a_wr_ptr),   32'(k % 16));
            if (k == 15) begin
                chk("wrap15_a_wrapped", 32'(a_wrapped), 32'd0);
                chk("wrap15_b_ready",   32'(b_st_ready), 32'd1);
                chk("wrap15_b_ptr",     32'(b_wr_ptr),   32'd15);
                chk("wrap15_b_done",    32'(b_done),     32'd0);
            end
            if (k == 16) begin
                chk("wrap16_a_wrapped", 32'(a_wrapped),   32'd1);
                chk("wrap16_b_ready",   32'(b_st_ready),  32'd0);
                chk("wrap16_b_done",    32'(b_done),      32'd1);
                chk("wrap16_b_cap",     32'(b_capturing), 32'd0);
                chk("wrap16_b_wrapped", 32'(b_wrapped),   32'd1);
                chk("wrap16_b_ptr",     32'(b_wr_ptr),    32'd0);
            end
        end
        tick();
        st_valid = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        chk("wrap_end_a_ptr",     32'(a_wr_ptr),    32'd4);
        chk("wrap_end_a_wrapped", 32'(a_wrapped),   32'd1);
        chk("wrap_end_a_cap",     32'(a_capturing), 32'd1);
        tick();
        stop = 1'b0;
        @(negedge clk);
        chk("stop_a_done", 32'(a_done),      32'd1);
        chk("stop_a_cap",  32'(a_capturing), 32'd0);
        chk("stop_b_done", 32'(b_done),      32'd1);
        host_read(4'd0,  32'd16, 32'd0,  "rd0");
        host_read(4'd3,  32'd19, 32'd3,  "rd3");
        host_read(4'd4,  32'd4,  32'd4,  "rd4");
        host_read(4'd15, 32'd15, 32'd15, "rd15");

        // ---- contention: host read of address 2 against a continuous stream ----
        tick();
        arm = 1'b1;
        @(negedge clk);
        idx = 0;
        pending = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            tick();
            arm = 1'b0;
            st_valid = 1'b1;
            st_data = 32'h11 * 32'(idx + 1);
            if (j == 5) begin
                pending = 1'b1;
                chipselect = 1'b1; read = 1'b1; address = 4'd2;
            end else if (!pending) begin
                chipselect = 1'b0; read = 1'b0;
            end
            @(negedge clk);
            if (j == 1) begin
                chk("arm_clears_a_wrapped", 32'(a_wrapped), 32'd0);
                chk("arm_clears_b_wrapped", 32'(b_wrapped), 32'd0);
            end
            if (j == 5) begin
                chk("cont5_a_wait",  32'(a_wait),     32'd1);
                chk("cont5_b_wait",  32'(b_wait),     32'd1);
                chk("cont5_ready",   32'(a_st_ready), 32'd1);
            end
            if (j == 6) begin
                chk("cont6_a_wait",  32'(a_wait),     32'd0);
                chk("cont6_ready",   32'(a_st_ready), 32'd0);
            end
            if (j == 7 || j == 9) begin
                chk($sformatf("cont%0d_rdv", j), 32'(a_rdv), 32'd0);
            end
            if (j == 8) begin
                chk("cont8_rdv",   32'(a_rdv),   32'd1);
                chk("cont8_rdata", a_readdata,   32'h33);
            end
            if (pending && !a_wait) begin
                pending = 1'b0;
            end
            if (a_st_ready) begin
                idx++;
            end
        end
        tick();
        idle_inputs();
        @(negedge clk);
        chk("cont_a_ptr", 32'(a_wr_ptr), 32'd8);
        chk("cont_b_ptr", 32'(b_wr_ptr), 32'd8);

        // ---- freeze, then reset in the middle of a capture ----
        tick();
        arm = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            tick();
            arm = 1'b0;
            st_valid = 1'b1;
            st_data = 32'(100 + k);
            @(negedge clk);
        end
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        chk("mid_a_ptr", 32'(a_wr_ptr),    32'd7);
        chk("mid_a_cap", 32'(a_capturing), 32'd1);
        tick();
        clken = 1'b0; st_valid = 1'b1; chipselect = 1'b1; read = 1'b1;
        @(negedge clk);
        chk("clken_ready", 32'(a_st_ready), 32'd0);
        chk("clken_wait",  32'(a_wait),     32'd1);
        tick();
        clken = 1'b1; reset_req = 1'b1;
        @(negedge clk);
        chk("rreq_ready", 32'(a_st_ready), 32'd0);
        chk("rreq_wait",  32'(a_wait),     32'd1);
        tick();
        reset_req = 1'b0; chipselect = 1'b0; read = 1'b0;
        @(negedge clk);
        chk("freeze_a_ptr", 32'(a_wr_ptr), 32'd7);
        // stream still valid and ready here; reset lands before the next edge
        #2;
        reset = 1'b1;
        #1;
        chk("arst_a_ptr",   32'(a_wr_ptr),    32'd0);
        chk("arst_b_ptr",   32'(b_wr_ptr),    32'd0);
        chk("arst_a_cap",   32'(a_capturing), 32'd0);
        chk("arst_wait",    32'(a_wait),      32'd1);
        chk("arst_ready",   32'(a_st_ready),  32'd0);
        chk("arst_rdata",   a_readdata,       32'd0);
        chk("arst_rdv",     32'(a_rdv),       32'd0);
        tick();
        @(negedge clk);
        chk("arst_hold_wait", 32'(a_wait), 32'd1);
        tick();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("post_rst_cap",     32'(a_capturing), 32'd0);
        chk("post_rst_ptr",     32'(a_wr_ptr),    32'd0);
        chk("post_rst_done",    32'(a_done),      32'd0);
        chk("post_rst_wrapped", 32'(a_wrapped),   32'd0);
        chk("post_rst_wait",    32'(a_wait),      32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
